// File: rtl/adder.sv
// Registered WIDTH-bit two's-complement adder built from a ripple chain of full-adder cells.
// Sum and Overflow come straight from flops; the adder's final carry-out is not used.

module adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             En,
  output logic [WIDTH-1:0] Sum,
  output logic             Overflow
);
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] s;
  logic             cout_unused;
  logic             v;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    if (i < WIDTH-1) begin : g_mid
      adder_fa u_fa (.a(A[i]), .b(B[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end else begin : g_msb
      adder_fa u_fa (.a(A[i]), .b(B[i]), .ci(c[i]), .s(s[i]), .co(cout_unused));
    end
  end

  // Signed overflow: the operands have the same sign and the sum's sign differs from it.
  assign v = (A[WIDTH-1] == B[WIDTH-1]) && (s[WIDTH-1] != A[WIDTH-1]);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Sum      <= '0;
      Overflow <= 1'b0;
    end else if (En) begin
      Sum      <= s;
      Overflow <= v;
    end
  end
endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: a reference model queues the expected outputs at each edge,
// and a monitor compares them against the DUT just after that edge.
`timescale 1ns/100ps

module tb_adder;
  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [W-1:0] A, B;
  logic         En;
  logic [W-1:0] Sum;
  logic         Overflow;

  int checks = 0;
  int errors = 0;

  typedef struct { int s; int v; } exp_t;
  exp_t q[$];
  int   ms = 0, mo = 0;

  adder #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .A(A), .B(B), .En(En), .Sum(Sum), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  function automatic int to_signed(input logic [W-1:0] x);
    return (int'(x) >= 2**(W-1)) ? int'(x) - 2**W : int'(x);
  endfunction

  // Reference model: sums are computed as integers, then wrapped and range-checked.
  always @(posedge Clk) begin
    exp_t e;
    int   st;
    if (!Rst_n) begin
      ms = 0; mo = 0;
    end else if (En) begin
      ms = (int'(A) + int'(B)) % (2**W);
      st = to_signed(A) + to_signed(B);
      mo = (st > 2**(W-1) - 1 || st < -(2**(W-1))) ? 1 : 0;
    end
    e.s = ms; e.v = mo;
    q.push_back(e);
  end

  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (int'(Sum) != e.s || int'(Overflow) != e.v) begin
        errors++;
        $display("FAIL sb t=%0t: Sum=%0d Overflow=%0d expected Sum=%0d Overflow=%0d",
                 $time, Sum, Overflow, e.s, e.v);
      end
    end
  end

  task automatic chk(input string nm, input int es, input int eo);
    checks++;
    if (int'(Sum) != es || int'(Overflow) != eo) begin
      errors++;
      $display("FAIL %s: Sum=%0d Overflow=%0d expected Sum=%0d Overflow=%0d",
               nm, Sum, Overflow, es, eo);
    end
  endtask

  task automatic apply(input int a, input int b, input logic e);
    @(negedge Clk);
    A = W'(a); B = W'(b); En = e;
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Rst_n = 1'b0; En = 1'b1; A = 4'd5; B = 4'd6;
    repeat (2) @(posedge Clk);
    #2 chk("reset", 0, 0);
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk);
    #2 chk("release_5p6", 11, 1);

    apply(3, 4, 1'b1);  chk("3p4", 7, 0);
    apply(4, 4, 1'b1);  chk("4p4", 8, 1);
    apply(15, 1, 1'b1); chk("m1p1", 0, 0);
    apply(8, 8, 1'b1);  chk("m8pm8", 0, 1);
    apply(8, 15, 1'b1); chk("m8pm1", 7, 1);
    apply(2, 3, 1'b1);  chk("2p3", 5, 0);
    for (int i = 0; i < 3; i++) begin
      apply(7, 7, 1'b0); chk("hold", 5, 0);
    end
    apply(7, 7, 1'b1);  chk("7p7", 14, 1);

    // Reset in the middle of a stream discards the pending result.
    apply(7, 1, 1'b1);  chk("7p1", 8, 1);
    @(negedge Clk) begin Rst_n = 1'b0; A = 4'd1; B = 4'd1; En = 1'b1; end
    @(posedge Clk);
    #2 chk("midreset", 0, 0);
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk);
    #2 chk("after_reset", 2, 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        apply(a, b, 1'b1);

    // Operands change every 3 ns, never on a clock edge.
    @(negedge Clk);
    #0.5;
    for (int v = 0; v < 16; v++) begin
      A = W'(v); B = W'(v);
      #3;
    end

    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      A     = W'($urandom);
      B     = W'($urandom);
      En    = ($urandom_range(0, 3) != 0);
      Rst_n = ($urandom_range(0, 19) != 0);
    end

    @(negedge Clk) Rst_n = 1'b1;
    repeat (2) @(posedge Clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
